// File: rtl/moldudp_feed_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : moldudp_feed_arbiter_if
// Description : 64-bit AXI-stream UDP payload bundle (tvalid/tready/tdata/
//               tkeep/tlast/tuser) shared by the arbiter inputs and output.
// Revision    : 1.0 - initial release
// ============================================================================
interface moldudp_feed_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tuser;

    modport master (output tvalid, output tdata, output tkeep, output tlast,
                    output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast,
                    input tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/moldudp_feed_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : moldudp_feed_arbiter
// Description : Packet-level round-robin arbiter between two UDP payload
//               streams feeding one MoldUDP64 decoder; registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module moldudp_feed_arbiter #(
    parameter int AXI_DATA_W = 64,
    parameter int AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int PKT_CNT_W  = 32
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    moldudp_feed_arbiter_if.slave     upd0,
    moldudp_feed_arbiter_if.slave     upd1,
    moldudp_feed_arbiter_if.master    upd,
    output logic [1:0]                grant_o,
    output logic [PKT_CNT_W-1:0]      pkt_cnt0_o,
    output logic [PKT_CNT_W-1:0]      pkt_cnt1_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_last_grant;
    logic                   r_tvalid;
    logic [AXI_DATA_W-1:0]  r_tdata;
    logic [AXI_KEEP_W-1:0]  r_tkeep;
    logic                   r_tlast;
    logic                   r_tuser;
    logic [PKT_CNT_W-1:0]   r_cnt0;
    logic [PKT_CNT_W-1:0]   r_cnt1;
    logic                   w_out_rdy;
    logic                   w_rdy0;
    logic                   w_rdy1;
    logic                   w_acc0;
    logic                   w_acc1;

    // Output register can take a beat when empty or being drained this cycle.
    assign w_out_rdy = ~r_tvalid | upd.tready;
    assign w_acc0    = upd0.tvalid & w_rdy0;
    assign w_acc1    = upd1.tvalid & w_rdy1;

    always_comb begin
        w_state_nxt = r_state;
        w_rdy0      = 1'b0;
        w_rdy1      = 1'b0;
        grant_o     = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (upd0.tvalid && upd1.tvalid)
                    w_state_nxt = r_last_grant ? ST_GNT0 : ST_GNT1;
                else if (upd0.tvalid)
                    w_state_nxt = ST_GNT0;
                else if (upd1.tvalid)
                    w_state_nxt = ST_GNT1;
            end
            ST_GNT0: begin
                w_rdy0     = w_out_rdy;
                grant_o[0] = 1'b1;
                if (upd0.tvalid && w_out_rdy && upd0.tlast)
                    w_state_nxt = ST_IDLE;
            end
            ST_GNT1: begin
                w_rdy1     = w_out_rdy;
                grant_o[1] = 1'b1;
                if (upd1.tvalid && w_out_rdy && upd1.tlast)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_tvalid     <= 1'b0;
            r_tdata      <= '0;
            r_tkeep      <= '0;
            r_tlast      <= 1'b0;
            r_tuser      <= 1'b0;
            r_cnt0       <= '0;
            r_cnt1       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_state_nxt == ST_GNT0)
                r_last_grant <= 1'b0;
            else if (r_state == ST_IDLE && w_state_nxt == ST_GNT1)
                r_last_grant <= 1'b1;

            if (w_acc0) begin
                r_tvalid <= 1'b1;
                r_tdata  <= upd0.tdata;
                r_tkeep  <= upd0.tkeep;
                r_tlast  <= upd0.tlast;
                r_tuser  <= upd0.tuser;
            end else if (w_acc1) begin
                r_tvalid <= 1'b1;
                r_tdata  <= upd1.tdata;
                r_tkeep  <= upd1.tkeep;
                r_tlast  <= upd1.tlast;
                r_tuser  <= upd1.tuser;
            end else if (upd.tready) begin
                r_tvalid <= 1'b0;
            end

            if (w_acc0 && upd0.tlast)
                r_cnt0 <= r_cnt0 + PKT_CNT_W'(1);
            if (w_acc1 && upd1.tlast)
                r_cnt1 <= r_cnt1 + PKT_CNT_W'(1);
        end
    end

    assign upd0.tready = w_rdy0;
    assign upd1.tready = w_rdy1;
    assign upd.tvalid  = r_tvalid;
    assign upd.tdata   = r_tdata;
    assign upd.tkeep   = r_tkeep;
    assign upd.tlast   = r_tlast;
    assign upd.tuser   = r_tuser;
    assign pkt_cnt0_o  = r_cnt0;
    assign pkt_cnt1_o  = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_moldudp_feed_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_moldudp_feed_arbiter
// Description : Directed self-checking bench for moldudp_feed_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moldudp_feed_arbiter;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    typedef struct {
        beat_t b;
        int    cyc;
    } rec_t;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    grant;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    beat_t q0[$];
    beat_t q1[$];
    beat_t expq[$];
    rec_t  outq[$];
    int    cyc    = 0;
    int    start0 = 0;
    int    n_chk  = 0;
    int    n_bad  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    moldudp_feed_arbiter_if #(.DATA_W(DW), .KEEP_W(KW)) u0 ();
    moldudp_feed_arbiter_if #(.DATA_W(DW), .KEEP_W(KW)) u1 ();
    moldudp_feed_arbiter_if #(.DATA_W(DW), .KEEP_W(KW)) dn ();

    moldudp_feed_arbiter #(
        .AXI_DATA_W (DW),
        .AXI_KEEP_W (KW),
        .PKT_CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .upd0       (u0),
        .upd1       (u1),
        .upd        (dn),
        .grant_o    (grant),
        .pkt_cnt0_o (cnt0),
        .pkt_cnt1_o (cnt1)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk(input int s, input int p, input int b, input bit last);
        beat_t r;
        r.d = {8'(s), 8'(p), 8'(b), 40'hC0FFEE1234};
        r.k = last ? 8'h3F : 8'hFF;
        r.l = last;
        r.u = (b == 1);
        return r;
    endfunction

    task automatic push_pkt(input int s, input int p, input int n);
        for (int b = 0; b < n; b++) begin
            if (s == 0) q0.push_back(mk(s, p, b, b == n - 1));
            else        q1.push_back(mk(s, p, b, b == n - 1));
        end
    endtask

    task automatic exp_pkt(input int s, input int p, input int n);
        for (int b = 0; b < n; b++) expq.push_back(mk(s, p, b, b == n - 1));
    endtask

    task automatic compare_out(input string tag);
        check({tag, " count"}, 128'(outq.size()), 128'(expq.size()));
        for (int i = 0; i < outq.size() && i < expq.size(); i++)
            check($sformatf("%s beat%0d", tag, i), 128'(outq[i].b), 128'(expq[i]));
        outq.delete();
        expq.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || u0.tvalid || u1.tvalid || dn.tvalid) && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({tag, " drained"}, 128'(n < 300), 128'(1));
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        outq.delete();
        expq.delete();
    endtask

    // Source models: present the queue head, pop once the handshake completes.
    initial begin
        bit acc;
        u0.tvalid = 1'b0; u0.tdata = '0; u0.tkeep = '0; u0.tlast = 1'b0; u0.tuser = 1'b0;
        forever begin
            @(negedge clk);
            acc = u0.tvalid && u0.tready && !reset;
            @(posedge clk);
            #1;
            if (reset) q0.delete();
            else if (acc) void'(q0.pop_front());
            if (q0.size() != 0) begin
                if (!u0.tvalid) start0 = cyc;
                u0.tvalid = 1'b1;
                {u0.tdata, u0.tkeep, u0.tlast, u0.tuser} = q0[0];
            end else begin
                u0.tvalid = 1'b0;
            end
        end
    end

    initial begin
        bit acc;
        u1.tvalid = 1'b0; u1.tdata = '0; u1.tkeep = '0; u1.tlast = 1'b0; u1.tuser = 1'b0;
        forever begin
            @(negedge clk);
            acc = u1.tvalid && u1.tready && !reset;
            @(posedge clk);
            #1;
            if (reset) q1.delete();
            else if (acc) void'(q1.pop_front());
            if (q1.size() != 0) begin
                u1.tvalid = 1'b1;
                {u1.tdata, u1.tkeep, u1.tlast, u1.tuser} = q1[0];
            end else begin
                u1.tvalid = 1'b0;
            end
        end
    end

    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (dn.tvalid && dn.tready && !reset) begin
                r.b   = {dn.tdata, dn.tkeep, dn.tlast, dn.tuser};
                r.cyc = cyc;
                outq.push_back(r);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t t1[5];
        bit    found;
        int    tl;
        int    fr;
        dn.tready = 1'b1;

        // Reset values
        reset_dut();
        check("rst tvalid", 128'(dn.tvalid), 128'(0));
        check("rst tdata",  128'(dn.tdata),  128'(0));
        check("rst tkeep",  128'(dn.tkeep),  128'(0));
        check("rst tlast",  128'(dn.tlast),  128'(0));
        check("rst tuser",  128'(dn.tuser),  128'(0));
        check("rst grant",  128'(grant),     128'(0));
        check("rst cnt0",   128'(cnt0),      128'(0));
        check("rst cnt1",   128'(cnt1),      128'(0));
        check("rst rdy0",   128'(u0.tready), 128'(0));
        check("rst rdy1",   128'(u1.tready), 128'(0));

        // Single MoldUDP64 packet on source 0
        t1[0] = '{d: 64'h0000_0000_0000_DEAD, k: 8'hFF, l: 1'b0, u: 1'b0};
        t1[1] = '{d: 64'hBEEF_F0F0_F0F0_F0F0, k: 8'hFF, l: 1'b0, u: 1'b0};
        t1[2] = '{d: 64'hF0F0_0001_0010_AAAA, k: 8'hFF, l: 1'b0, u: 1'b0};
        t1[3] = '{d: 64'hAAAA_AAAA_AAAA_AAAA, k: 8'hFF, l: 1'b0, u: 1'b1};
        t1[4] = '{d: 64'h0000_BBBB_BBBB_BBBB, k: 8'h0F, l: 1'b1, u: 1'b0};
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            q0.push_back(t1[i]);
            expq.push_back(t1[i]);
        end
        wait_idle("t1");
        check("t1 latency", 128'(outq.size() > 0 ? outq[0].cyc - start0 : -1), 128'(2));
        compare_out("t1");
        check("t1 cnt0",  128'(cnt0),  128'(1));
        check("t1 cnt1",  128'(cnt1),  128'(0));
        check("t1 grant", 128'(grant), 128'(0));

        // Simultaneous start: round-robin from a fresh reset
        reset_dut();
        @(negedge clk);
        push_pkt(0, 1, 3); push_pkt(0, 2, 3);
        push_pkt(1, 1, 3); push_pkt(1, 2, 3);
        exp_pkt(0, 1, 3); exp_pkt(1, 1, 3); exp_pkt(0, 2, 3); exp_pkt(1, 2, 3);
        wait_idle("t2");
        check("t2 intra gap", 128'(outq.size() >= 4 ? outq[1].cyc - outq[0].cyc : -1), 128'(1));
        check("t2 inter gap", 128'(outq.size() >= 4 ? outq[3].cyc - outq[2].cyc : -1), 128'(2));
        compare_out("t2");
        check("t2 cnt0", 128'(cnt0), 128'(2));
        check("t2 cnt1", 128'(cnt1), 128'(2));

        // Backpressure on beat 2
        @(negedge clk);
        push_pkt(0, 3, 5);
        exp_pkt(0, 3, 5);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #2;
            if (dn.tvalid && dn.tdata == mk(0, 3, 2, 1'b0).d) found = 1'b1;
        end
        check("t3 beat2 seen", 128'(found), 128'(1));
        dn.tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t3 hold%0d data", i), 128'(dn.tdata), 128'(mk(0, 3, 2, 1'b0).d));
            check($sformatf("t3 hold%0d rdy0", i), 128'(u0.tready), 128'(0));
            @(posedge clk);
            #2;
        end
        dn.tready = 1'b1;
        wait_idle("t3");
        compare_out("t3");
        check("t3 cnt0", 128'(cnt0), 128'(3));

        // Source 1 requests mid-packet
        @(negedge clk);
        push_pkt(0, 4, 4);
        exp_pkt(0, 4, 4);
        exp_pkt(1, 4, 3);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (u0.tvalid && u0.tdata == mk(0, 4, 1, 1'b0).d) found = 1'b1;
        end
        check("t4 beat1 seen", 128'(found), 128'(1));
        push_pkt(1, 4, 3);
        tl = -100;
        fr = -1;
        for (int i = 0; i < 40 && fr < 0; i++) begin
            @(negedge clk);
            if (u1.tready) fr = cyc;
            else if (u0.tvalid && u0.tready && u0.tlast) tl = cyc;
        end
        check("t4 rdy1 delay", 128'(fr - tl), 128'(2));
        wait_idle("t4");
        compare_out("t4");
        check("t4 cnt0", 128'(cnt0), 128'(4));
        check("t4 cnt1", 128'(cnt1), 128'(3));

        // Reset during beat 2 of a source 1 packet
        @(negedge clk);
        push_pkt(1, 5, 5);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (u1.tvalid && u1.tdata == mk(1, 5, 2, 1'b0).d) found = 1'b1;
        end
        check("t5 beat2 seen", 128'(found), 128'(1));
        #1 reset = 1'b1;
        @(posedge clk);
        #2;
        check("t5 tvalid", 128'(dn.tvalid), 128'(0));
        check("t5 tdata",  128'(dn.tdata),  128'(0));
        check("t5 tlast",  128'(dn.tlast),  128'(0));
        check("t5 grant",  128'(grant),     128'(0));
        check("t5 cnt0",   128'(cnt0),      128'(0));
        check("t5 cnt1",   128'(cnt1),      128'(0));
        check("t5 rdy1",   128'(u1.tready), 128'(0));
        reset = 1'b0;
        outq.delete();
        expq.delete();
        @(negedge clk);
        push_pkt(1, 6, 4);
        push_pkt(0, 6, 2);
        exp_pkt(0, 6, 2);
        exp_pkt(1, 6, 4);
        wait_idle("t5");
        compare_out("t5");
        check("t5 post cnt0", 128'(cnt0), 128'(1));
        check("t5 post cnt1", 128'(cnt1), 128'(1));

        // Counter wrap on a 4-bit counter
        reset_dut();
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            push_pkt(0, 16 + i, 1);
            exp_pkt(0, 16 + i, 1);
        end
        wait_idle("t6");
        compare_out("t6");
        check("t6 cnt0 wrap", 128'(cnt0), 128'(1));
        check("t6 cnt1",      128'(cnt1), 128'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
